// File: rtl/button_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_arb_pkg
// Description : Shared constants for the tug-of-war button arbiter:
//               FSM state encodings and default debounce sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_arb_pkg;

    // Arbiter FSM state encoding (1 bit, explicit width)
    localparam logic [0:0] ARMED  = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    // Default debounce window: ~10 ms at 50 MHz
    localparam int DEB_CYCLES_DEF = 500000;
    localparam int CNT_W_DEF      = 20;

endpackage : btn_arb_pkg
`default_nettype wire

// File: rtl/button_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : button_arbiter_if
// Description : Signal bundle between the button arbiter and its environment.
//               slave  : arbiter side (buttons/control in, decisions out)
//               master : environment side (drives buttons/control)
// Ports       : pbl, pbr     raw pushbuttons (async, active-high)
//               clr          round-clear pulse, re-arms the arbiter
//               leds_on      round lights lit (presses legal)
//               l_adv/r_adv  one-cycle rope advance pulses
//               l_jump/r_jump sticky early-press flags
//               locked       decision made, awaiting clr
// Revision    : 1.0 - initial release
// ============================================================================
interface button_arbiter_if;

    logic pbl;
    logic pbr;
    logic clr;
    logic leds_on;
    logic l_adv;
    logic r_adv;
    logic l_jump;
    logic r_jump;
    logic locked;

    modport slave (
        input  pbl, pbr, clr, leds_on,
        output l_adv, r_adv, l_jump, r_jump, locked
    );

    modport master (
        output pbl, pbr, clr, leds_on,
        input  l_adv, r_adv, l_jump, r_jump, locked
    );

endinterface : button_arbiter_if
`default_nettype wire

// File: rtl/button_arbiter_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : One pushbutton conditioner: 2-flop synchroniser, consecutive-
//               cycle debounce counter, registered rising-edge detector.
// Ports       : clk, rst     clock / synchronous active-high reset
//               raw          asynchronous raw button level
//               press        one-cycle pulse on debounced 0->1
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import btn_arb_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic raw,
    output logic      press
);

    // Count value on the last of DEB_CYCLES consecutive mismatch cycles
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            // Count only while the synced value disagrees with the level;
            // any agreeing cycle restarts the window.
            if (r_sync2 != r_level) begin
                if (r_cnt == c_cnt_last) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign press = r_press;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/button_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : button_arbiter
// Description : Input stage for the tug-of-war game. Debounces both buttons,
//               picks one winner per round, emits one-cycle advance pulses and
//               locks until the game FSM pulses clr.
//               Build option: define BTN_ARB_JUMP_PENALTY_EN to penalise presses
//               made while the lights are off (the opponent advances and the
//               presser's jump flag is set). Undefined: such presses are ignored.
// Ports       : clk, rst     clock / synchronous active-high reset
//               bus          button_arbiter_if.slave (buttons, clr, leds_on in;
//                            l_adv, r_adv, l_jump, r_jump, locked out)
// Revision    : 1.0 - initial release
// ============================================================================
module button_arbiter
    import btn_arb_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  wire logic         clk,
    input  wire logic         rst,
    button_arbiter_if.slave   bus
);

    logic       w_press_l;
    logic       w_press_r;

    logic [0:0] r_state;
    logic [0:0] w_next_state;
    logic       r_l_adv;
    logic       r_r_adv;
    logic       r_l_jump;
    logic       r_r_jump;
    logic       w_l_adv;
    logic       w_r_adv;
    logic       w_l_jump;
    logic       w_r_jump;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_deb_l (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.pbl),
        .press (w_press_l)
    );

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_deb_r (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.pbr),
        .press (w_press_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ARMED;
            r_l_adv  <= 1'b0;
            r_r_adv  <= 1'b0;
            r_l_jump <= 1'b0;
            r_r_jump <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_l_adv  <= w_l_adv;
            r_r_adv  <= w_r_adv;
            r_l_jump <= w_l_jump;
            r_r_jump <= w_r_jump;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_l_adv      = 1'b0;
        w_r_adv      = 1'b0;
`ifdef BTN_ARB_JUMP_PENALTY_EN
        w_l_jump     = r_l_jump;
        w_r_jump     = r_r_jump;
`else
        w_l_jump     = 1'b0;
        w_r_jump     = 1'b0;
`endif
        if (bus.clr) begin
            // clr wins over a same-cycle press; that press is dropped
            w_next_state = ARMED;
            w_l_jump     = 1'b0;
            w_r_jump     = 1'b0;
        end else begin
            case (r_state)
                ARMED: begin
                    // Simultaneous presses are a tie: nothing happens
                    if (w_press_l && !w_press_r) begin
                        if (bus.leds_on) begin
                            w_l_adv      = 1'b1;
                            w_next_state = LOCKED;
                        end
`ifdef BTN_ARB_JUMP_PENALTY_EN
                        else begin
                            w_r_adv      = 1'b1;
                            w_l_jump     = 1'b1;
                            w_next_state = LOCKED;
                        end
`endif
                    end else if (w_press_r && !w_press_l) begin
                        if (bus.leds_on) begin
                            w_r_adv      = 1'b1;
                            w_next_state = LOCKED;
                        end
`ifdef BTN_ARB_JUMP_PENALTY_EN
                        else begin
                            w_l_adv      = 1'b1;
                            w_r_jump     = 1'b1;
                            w_next_state = LOCKED;
                        end
`endif
                    end
                end
                default: begin
                    // LOCKED: presses are discarded until clr
                    w_next_state = LOCKED;
                end
            endcase
        end
    end

    assign bus.l_adv  = r_l_adv;
    assign bus.r_adv  = r_r_adv;
    assign bus.l_jump = r_l_jump;
    assign bus.r_jump = r_r_jump;
    assign bus.locked = (r_state == LOCKED);

endmodule : button_arbiter
`default_nettype wire
